// File: rtl/tdes_word_demux_pkg.sv
// Shared definitions for the TDES word-to-block demultiplexer slice.
// Holds the half/block widths and the pairing FSM state encoding.
package tdes_defs;

  localparam int TDES_HALF_W = 32;
  localparam int TDES_BLK_W  = 64;

  typedef enum logic {
    ST_WAIT_FIRST  = 1'b0,
    ST_WAIT_SECOND = 1'b1
  } state_t;

endpackage

// File: rtl/tdes_word_demux_if.sv
// Host word stream in, L/R block stream out, plus clear and status.
// The master modport is the host/core side; the slave modport is the demux.
interface tdes_word_demux_if;
  import tdes_defs::*;

  logic                   clr;
  logic [1:TDES_HALF_W]   in_word;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:TDES_HALF_W]   blk_l;
  logic [1:TDES_HALF_W]   blk_r;
  logic                   blk_valid;
  logic                   blk_ready;
  logic                   half_pending;
  logic                   drop_pulse;

  modport master (
    output clr, in_word, in_valid, blk_ready,
    input  in_ready, blk_l, blk_r, blk_valid, half_pending, drop_pulse
  );

  modport slave (
    input  clr, in_word, in_valid, blk_ready,
    output in_ready, blk_l, blk_r, blk_valid, half_pending, drop_pulse
  );

endinterface

// File: rtl/tdes_word_demux_blk_fifo2.sv
// Two-entry 64-bit block buffer with 1-bit wrapping pointers and a 0..2 count.
// Exposes next-cycle count so the producer can register its ready flag.
module tdes_blk_fifo2
  import tdes_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  i_push,
  input  logic [TDES_BLK_W-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [TDES_BLK_W-1:0] o_rdata,
  output logic                  o_empty,
  output logic [1:0]            o_count_nxt
);

  logic [TDES_BLK_W-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_count_nxt;

  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop  && (r_count != 2'd0);

  // Simultaneous push and pop leaves the count unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (clr)                 w_count_nxt = 2'd0;
    else if (w_push && !w_pop) w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_count <= w_count_nxt;
      if (clr) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= i_wdata;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  assign o_rdata     = r_mem[r_rd_ptr];
  assign o_empty     = (r_count == 2'd0);
  assign o_count_nxt = w_count_nxt;

endmodule

// File: rtl/tdes_word_demux.sv
// Pairs incoming 32-bit words into 64-bit L/R blocks and queues them for the
// TDES core; L_FIRST selects whether the first word of a pair is L or R.
module tdes_word_demux
  import tdes_defs::*;
#(
  parameter logic L_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  tdes_word_demux_if.slave  bus
);

  state_t                r_state;
  logic [1:TDES_HALF_W]  r_first;
  logic                  r_in_ready;
  logic                  r_drop;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [1:0]            w_count_nxt;
  logic [TDES_BLK_W-1:0] w_blk;
  logic [TDES_BLK_W-1:0] w_rdata;

  // Handshakes presented during clr are ignored
  assign w_accept = bus.in_valid && r_in_ready && !bus.clr;
  assign w_push   = w_accept && (r_state == ST_WAIT_SECOND);
  assign w_pop    = !w_empty && bus.blk_ready && !bus.clr;
  assign w_blk    = L_FIRST ? {r_first, bus.in_word} : {bus.in_word, r_first};

  tdes_blk_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr         (bus.clr),
    .i_push      (w_push),
    .i_wdata     (w_blk),
    .i_pop       (w_pop),
    .o_rdata     (w_rdata),
    .o_empty     (w_empty),
    .o_count_nxt (w_count_nxt)
  );

  // in_ready is registered from the next-cycle buffer count: no path from blk_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_WAIT_FIRST;
      r_first    <= '0;
      r_in_ready <= 1'b0;
      r_drop     <= 1'b0;
    end else if (bus.clr) begin
      r_state    <= ST_WAIT_FIRST;
      r_in_ready <= 1'b1;
      r_drop     <= (r_state == ST_WAIT_SECOND) || !w_empty;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        ST_WAIT_FIRST: begin
          if (w_accept) begin
            r_first    <= bus.in_word;
            r_state    <= ST_WAIT_SECOND;
            r_in_ready <= (w_count_nxt < 2'd2);
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_WAIT_SECOND: begin
          if (w_accept) begin
            r_state    <= ST_WAIT_FIRST;
            r_in_ready <= 1'b1;
          end else begin
            r_in_ready <= (w_count_nxt < 2'd2);
          end
        end
        default: r_state <= ST_WAIT_FIRST;
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.blk_valid    = !w_empty;
  assign bus.blk_l        = w_rdata[TDES_BLK_W-1:TDES_HALF_W];
  assign bus.blk_r        = w_rdata[TDES_HALF_W-1:0];
  assign bus.half_pending = (r_state == ST_WAIT_SECOND);
  assign bus.drop_pulse   = r_drop;

endmodule

// File: tb/tb_tdes_word_demux.sv
// Drives one word stream into an L_FIRST=1 and an L_FIRST=0 demux in parallel;
// a negedge monitor checks every consumed block against a queue of expected pairs.
module tb_tdes_word_demux;
  import tdes_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        blk_ready = 1'b0;
  logic [1:32] in_word = '0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  logic [63:0] e1;
  logic [63:0] e0;

  always #5 clk = ~clk;

  tdes_word_demux_if bus1();
  tdes_word_demux_if bus0();

  assign bus1.clr = clr;       assign bus0.clr = clr;
  assign bus1.in_word = in_word;   assign bus0.in_word = in_word;
  assign bus1.in_valid = in_valid; assign bus0.in_valid = in_valid;
  assign bus1.blk_ready = blk_ready; assign bus0.blk_ready = blk_ready;

  tdes_word_demux #(.L_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  tdes_word_demux #(.L_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a block is consumed at the next posedge when valid&&ready
  always @(negedge clk) begin
    if (!rst && !clr && blk_ready && bus1.blk_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL blk1_unexpected actual=%h_%h expected=none", bus1.blk_l, bus1.blk_r);
      end else begin
        e1 = q1.pop_front();
        chk("blk1_l", bus1.blk_l, e1[63:32]);
        chk("blk1_r", bus1.blk_r, e1[31:0]);
      end
    end
    if (!rst && !clr && blk_ready && bus0.blk_valid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL blk0_unexpected actual=%h_%h expected=none", bus0.blk_l, bus0.blk_r);
      end else begin
        e0 = q0.pop_front();
        chk("blk0_l", bus0.blk_l, e0[31:0]);
        chk("blk0_r", bus0.blk_r, e0[63:32]);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge
  task automatic send_word(input logic [1:32] w, output int tries);
    logic acc;
    in_word  = w;
    in_valid = 1'b1;
    tries    = 0;
    acc      = 1'b0;
    while (!acc && tries < 40) begin
      tries++;
      @(negedge clk);
      acc = bus1.in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL word_accept_timeout actual=not_accepted expected=accepted word=%h", w);
    end
  endtask

  task automatic send_pair(input logic [1:32] a, input logic [1:32] b);
    int t;
    q1.push_back({a, b});
    q0.push_back({a, b});
    send_word(a, t);
    send_word(b, t);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d/%0d left expected=0", name, q1.size(), q0.size());
    end
    chk({name, "_empty_valid"}, bus1.blk_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [1:32] a, b;

    // Reset state
    #12;
    chk("rst_in_ready1", bus1.in_ready, 0);
    chk("rst_in_ready0", bus0.in_ready, 0);
    chk("rst_blk_valid", bus1.blk_valid, 0);
    chk("rst_blk_l", bus1.blk_l, 0);
    chk("rst_blk_r", bus1.blk_r, 0);
    chk("rst_half_pending", bus1.half_pending, 0);
    chk("rst_drop_pulse", bus1.drop_pulse, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rel_in_ready_pre_clk", bus1.in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_post_clk", bus1.in_ready, 1);

    // Basic pair and latency
    blk_ready = 1'b1;
    q1.push_back({32'h01234567, 32'h89ABCDEF});
    q0.push_back({32'h01234567, 32'h89ABCDEF});
    send_word(32'h01234567, t);
    chk("pair_half_pending", bus1.half_pending, 1);
    chk("pair_valid_early", bus1.blk_valid, 0);
    send_word(32'h89ABCDEF, t);
    chk("pair_valid_latency", bus1.blk_valid, 1);
    chk("pair_half_clear", bus1.half_pending, 0);
    @(posedge clk); #1;
    chk("pair_popped", bus1.blk_valid, 0);

    // Swapped steering on the L_FIRST=0 instance
    blk_ready = 1'b0;
    send_pair(32'hAAAAAAAA, 32'h55555555);
    chk("lfirst0_l", bus0.blk_l, 32'h55555555);
    chk("lfirst0_r", bus0.blk_r, 32'hAAAAAAAA);
    chk("lfirst1_l", bus1.blk_l, 32'hAAAAAAAA);
    blk_ready = 1'b1;
    wait_drain("lfirst");

    // Backpressure and full buffer
    blk_ready = 1'b0;
    send_pair(32'h11111111, 32'h22222222);
    send_pair(32'h33333333, 32'h44444444);
    q1.push_back({32'h55555555, 32'h66666666});
    q0.push_back({32'h55555555, 32'h66666666});
    send_word(32'h55555555, t);
    chk("full_half_pending", bus1.half_pending, 1);
    chk("full_in_ready", bus1.in_ready, 0);
    chk("full_head_l", bus1.blk_l, 32'h11111111);
    in_word  = 32'h66666666;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", bus1.in_ready, 0);
      @(posedge clk); #1;
    end
    chk("stall_half_held", bus1.half_pending, 1);
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    chk("pop_in_ready_rise", bus1.in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sixth_accepted", bus1.half_pending, 0);
    chk("head_after_pop", bus1.blk_l, 32'h33333333);
    blk_ready = 1'b1;
    wait_drain("full");

    // Streaming: one word per cycle with simultaneous push/pop
    blk_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      q1.push_back({a, b});
      q0.push_back({a, b});
      send_word(a, t);
      chk("stream_first_tries", t, 1);
      send_word(b, t);
      chk("stream_second_tries", t, 1);
    end
    wait_drain("stream");

    // clr while idle does not pulse
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_idle_drop", bus1.drop_pulse, 0);

    // clr mid-pair with a word offered in the same cycle
    send_word(32'hDEADBEEF, t);
    chk("clr_pre_half", bus1.half_pending, 1);
    clr      = 1'b1;
    in_word  = 32'hCAFEF00D;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_drop_pulse1", bus1.drop_pulse, 1);
    chk("clr_drop_pulse0", bus0.drop_pulse, 1);
    chk("clr_half_pending", bus1.half_pending, 0);
    chk("clr_blk_valid", bus1.blk_valid, 0);
    chk("clr_in_ready", bus1.in_ready, 1);
    @(posedge clk); #1;
    chk("clr_drop_one_cycle", bus1.drop_pulse, 0);
    send_pair(32'h13579BDF, 32'h2468ACE0);
    wait_drain("clr");

    // Async reset with two blocks buffered
    blk_ready = 1'b0;
    send_pair(32'h0F0F0F0F, 32'hF0F0F0F0);
    send_pair(32'h12121212, 32'h34343434);
    chk("arst_pre_valid", bus1.blk_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_blk_valid1", bus1.blk_valid, 0);
    chk("arst_blk_valid0", bus0.blk_valid, 0);
    chk("arst_in_ready1", bus1.in_ready, 0);
    chk("arst_in_ready0", bus0.in_ready, 0);
    q1.delete();
    q0.delete();
    @(negedge clk); rst = 1'b0;
    #1;
    chk("arst_rel_in_ready", bus1.in_ready, 0);
    chk("arst_no_drop", bus1.drop_pulse, 0);
    @(posedge clk); #1;
    chk("arst_in_ready_clk", bus1.in_ready, 1);
    chk("arst_no_drop_clk", bus1.drop_pulse, 0);
    blk_ready = 1'b1;
    send_pair(32'hA5A5A5A5, 32'h5A5A5A5A);
    wait_drain("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
